// File: rtl/vedic_seq_divider_pkg.sv
//------------------------------------------------------------------------------
// Module : vedic_seq_divider_pkg
// Brief  : Shared types and constants for the sequential restoring divider.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package vedic_seq_divider_pkg;

  // Default operand width for the divider datapath
  localparam int DEFAULT_WIDTH = 16;

  // Quotient reported when the divisor is zero (all ones at the default width)
  localparam logic [DEFAULT_WIDTH-1:0] DIV0_Q = '1;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage : vedic_seq_divider_pkg

`default_nettype wire

// File: rtl/vedic_seq_divider_div_restore_step.sv
//------------------------------------------------------------------------------
// Module : div_restore_step
// Brief  : One combinational restoring-division iteration. Shifts the next
//          dividend bit into the partial remainder, trial-subtracts the
//          divisor and keeps the difference when it does not borrow.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module div_restore_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH:0]   o_rem,
  output logic             o_qbit
);

  // Shifted remainder carries one extra bit so the borrow of the trial
  // subtraction lands in the MSB of w_trial.
  logic [WIDTH+1:0] w_shifted;
  logic [WIDTH+1:0] w_trial;
  logic             w_borrow;

  // Trial subtraction and restore selection
  always_comb begin
    w_shifted = {i_rem, i_bit};
    w_trial   = w_shifted - {2'b00, i_divisor};
    w_borrow  = w_trial[WIDTH+1];
    o_qbit    = ~w_borrow;
    o_rem     = w_borrow ? w_shifted[WIDTH:0] : w_trial[WIDTH:0];
  end

endmodule : div_restore_step

`default_nettype wire

// File: rtl/vedic_seq_divider.sv
//------------------------------------------------------------------------------
// Module : vedic_seq_divider
// Brief  : Multi-cycle unsigned restoring divider, one quotient bit per cycle.
//          Quotient bits are shifted into the dividend register as the
//          dividend bits are consumed, so a single register holds both.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module vedic_seq_divider
  import vedic_seq_divider_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             div_by_zero
);

  localparam logic [CNT_W-1:0] C_CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

  div_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dvd;      // dividend bits out, quotient bits in
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH:0]   r_rem;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_r;
  logic             r_dz;

  logic [WIDTH:0]   w_rem_next;
  logic             w_qbit;

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_rem     (r_rem),
    .i_bit     (r_dvd[WIDTH-1]),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_next),
    .o_qbit    (w_qbit)
  );

  // Controller, iteration counter, working registers and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_rem   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_busy <= 1'b1;
            r_dvd  <= a;
            r_dvs  <= b;
            r_rem  <= '0;
            if (b == '0) begin
              // Divide by zero finishes immediately with a saturated quotient
              r_q     <= '1;
              r_r     <= a;
              r_dz    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_cnt   <= C_CNT_INIT;
              r_dz    <= 1'b0;
              r_state <= ST_CALC;
            end
          end
        end

        ST_CALC: begin
          r_dvd <= {r_dvd[WIDTH-2:0], w_qbit};
          r_rem <= w_rem_next;
          r_cnt <= r_cnt - C_CNT_ONE;
          if (r_cnt == C_CNT_ONE) begin
            // Last iteration: publish results on the edge entering DONE
            r_q     <= {r_dvd[WIDTH-2:0], w_qbit};
            r_r     <= w_rem_next[WIDTH-1:0];
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end

        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end

        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs come straight from registers
  always_comb begin
    busy        = r_busy;
    done        = r_done;
    q           = r_q;
    r           = r_r;
    div_by_zero = r_dz;
  end

endmodule : vedic_seq_divider

`default_nettype wire

// File: tb/tb_vedic_seq_divider.sv
//------------------------------------------------------------------------------
// Module : tb_vedic_seq_divider
// Brief  : Self-checking bench for vedic_seq_divider with a result scoreboard.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_vedic_seq_divider;

  localparam int W = 16;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         div_by_zero;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  vedic_seq_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .q           (q),
    .r           (r),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Push the reference result for an operand pair
  task automatic push_expect(input logic [W-1:0] ia, input logic [W-1:0] ib);
    exp_t e;
    e.a = ia;
    e.b = ib;
    if (ib == 0) begin
      e.q = {W{1'b1}}; e.r = ia; e.dz = 1'b1;
    end else begin
      e.q = ia / ib; e.r = ia % ib; e.dz = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Issue one operation and check it at done. p1/p2 are cycle numbers
  // (1 = cycle after the start edge) at which a stray start with a=b=1 is
  // driven; chk_hold checks that q/r keep their prior values while busy.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input int exp_lat, input bit chk_hold,
                       input int p1, input int p2);
    logic [W-1:0] pq, pr;
    exp_t e;
    int   c;
    bit   got;
    longint unsigned recon;
    push_expect(ia, ib);
    @(negedge clk);
    pq = q; pr = r;
    a = ia; b = ib; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    c = 1; got = 1'b0;
    while (!got && c <= 40) begin
      if (done === 1'b1) begin
        got = 1'b1;
        e = sb.pop_front();
        n_tests++;
        if (c != exp_lat) begin
          n_fail++; $display("FAIL latency a=%0d b=%0d: got cycle %0d, want %0d", e.a, e.b, c, exp_lat);
        end
        n_tests++;
        if (q !== e.q) begin
          n_fail++; $display("FAIL quotient a=%0d b=%0d: got %0d, want %0d", e.a, e.b, q, e.q);
        end
        n_tests++;
        if (r !== e.r) begin
          n_fail++; $display("FAIL remainder a=%0d b=%0d: got %0d, want %0d", e.a, e.b, r, e.r);
        end
        n_tests++;
        if (div_by_zero !== e.dz) begin
          n_fail++; $display("FAIL div_by_zero a=%0d b=%0d: got %0b, want %0b", e.a, e.b, div_by_zero, e.dz);
        end
        if (!e.dz) begin
          recon = longint'(q) * longint'(e.b) + longint'(r);
          n_tests++;
          if (recon != longint'(e.a) || r >= e.b) begin
            n_fail++; $display("FAIL identity a=%0d b=%0d: q*b+r=%0d r=%0d, want %0d with r<b", e.a, e.b, recon, r, e.a);
          end
        end
        if (c == p2) begin
          a = 1; b = 1; start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          n_fail++; $display("FAIL post_done: busy=%0b done=%0b, want 0 0", busy, done);
        end
      end else begin
        n_tests++;
        if (busy !== 1'b1) begin
          n_fail++; $display("FAIL busy cycle %0d: got %0b, want 1", c, busy);
        end
        if (chk_hold) begin
          n_tests++;
          if (q !== pq || r !== pr) begin
            n_fail++; $display("FAIL hold cycle %0d: q=%0d r=%0d, want q=%0d r=%0d", c, q, r, pq, pr);
          end
        end
        if (c == p1 || c == p2) begin
          a = 1; b = 1; start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        c++;
      end
    end
    start = 1'b0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL timeout a=%0d b=%0d: no done within 40 cycles", ia, ib);
      void'(sb.pop_front());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({busy, done, q, r, div_by_zero} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%0b done=%0b q=%0d r=%0d dz=%0b, want all 0", busy, done, q, r, div_by_zero);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({busy, done, q, r, div_by_zero} !== '0) begin
      n_fail++; $display("FAIL reset_release: busy=%0b done=%0b q=%0d r=%0d dz=%0b, want all 0", busy, done, q, r, div_by_zero);
    end
  endtask

  task automatic test_basic();
    do_op(16'd100, 16'd7, 17, 1'b1, 0, 0);
  endtask

  task automatic test_boundaries();
    do_op(16'hFFFF, 16'd1, 17, 1'b0, 0, 0);
    do_op(16'hFFFF, 16'hFFFF, 17, 1'b0, 0, 0);
    do_op(16'd3, 16'd10, 17, 1'b0, 0, 0);
    do_op(16'd0, 16'd5, 17, 1'b0, 0, 0);
  endtask

  task automatic test_div_zero();
    do_op(16'd5, 16'd0, 1, 1'b0, 0, 0);
    do_op(16'd9, 16'd3, 17, 1'b0, 0, 0);
  endtask

  task automatic test_ignore_start();
    int extra = 0;
    do_op(16'd200, 16'd9, 17, 1'b1, 6, 17);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_tests++;
    if (extra != 0) begin
      n_fail++; $display("FAIL ignore_start: extra done pulses=%0d, want 0", extra);
    end
  endtask

  task automatic test_reset_abort();
    int seen = 0;
    push_expect(16'd1000, 16'd3);
    @(negedge clk);
    a = 16'd1000; b = 16'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, q, r, div_by_zero} !== '0) begin
      n_fail++; $display("FAIL reset_abort: busy=%0b done=%0b q=%0d r=%0d dz=%0b, want all 0", busy, done, q, r, div_by_zero);
    end
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_no_done: done pulses=%0d, want 0", seen);
    end
    do_op(16'd1000, 16'd3, 17, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 500; i++) begin
      ra = W'($urandom);
      case (i % 5)
        0: rb = W'(1) << (i % W);
        1: begin rb = W'($urandom_range(1, 255)); ra = (i % 10 == 1) ? '0 : ra; end
        default: rb = W'($urandom_range(1, 65535));
      endcase
      do_op(ra, rb, 17, 1'b0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_div_zero();
    test_ignore_start();
    test_reset_abort();
    test_random();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_empty: %0d entries left, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_vedic_seq_divider

`default_nettype wire

// File: doc/vedic_seq_divider.md
Name: vedic_seq_divider

Overview:
Multi-cycle unsigned integer divider: the inverse operation of the team's Vedic multiplier tree. It accepts a dividend/divisor pair with a start pulse and produces quotient and remainder using restoring division, one quotient bit per cycle. It is used to check multiplier products (product / a == b, remainder 0) and as the standalone division datapath in the arithmetic block.

Parameters:
- WIDTH, 16, operand width in bits; quotient and remainder are also WIDTH bits.
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  dividend, unsigned.
- b  input  WIDTH  divisor, unsigned.
- busy  output  1  high from the accepted start edge until DONE exits.
- done  output  1  one-cycle pulse; results valid.
- q  output  WIDTH  quotient, registered.
- r  output  WIDTH  remainder, registered.
- div_by_zero  output  1  registered flag for the last operation.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - busy=0, done=0, q=0, r=0, div_by_zero=0, counter=0.
  - Reset asserted mid-operation aborts the operation; no done pulse follows.
- States: IDLE, CALC, DONE.
- IDLE + start=1 at edge k:
  - Latch a and b into internal registers; busy=1 from edge k.
  - If b==0: go to DONE; results are q=all-ones, r=a, div_by_zero=1.
  - Else: go to CALC with partial remainder=0, counter=WIDTH, div_by_zero=0.
- CALC, each edge:
  - Shift {partial remainder, dividend} left by 1.
  - Trial = partial remainder minus divisor, computed at WIDTH+1 bits.
  - If the trial is non-negative: remainder=trial and shift in quotient bit 1. Otherwise keep the remainder and shift in 0.
  - Decrement the counter; when it reaches 1, the transition goes to DONE.
  - CALC occupies exactly WIDTH cycles.
- DONE: done=1 for exactly one cycle; q and r are loaded on the edge entering DONE; next edge goes to IDLE with busy=0.
- Latency:
  - Nonzero divisor: done is high in the cycle beginning WIDTH+1 edges after the start edge (17 for WIDTH=16).
  - Zero divisor: done is high in the cycle beginning 1 edge after the start edge.
  - Throughput is one operation per WIDTH+2 cycles.
- q, r and div_by_zero hold their values until the next result is loaded. They do not change during CALC; only internal working registers change.
- start while busy (CALC or DONE) is ignored and not queued. Changes on a and b after acceptance have no effect.
- Width rules:
  - The remainder register is WIDTH+1 bits internally so the subtract borrow is visible.
  - Outputs are truncated to WIDTH.
  - r < b always holds when div_by_zero=0.
- Boundary cases:
  - a < b gives q=0, r=a.
  - a==b gives q=1, r=0.
  - b==1 gives q=a, r=0.
  - a==0 gives q=0, r=0 after the full WIDTH-cycle latency (no early exit).

Decomposition:
- Shared arithmetic package:
  - State enum (IDLE/CALC/DONE).
  - Default WIDTH=16.
  - Constant DIV0_Q = all-ones quotient for divide-by-zero.
- One natural sub-module: div_restore_step, a combinational single iteration.
  - Inputs: partial remainder, next dividend bit, divisor.
  - Outputs: next remainder, quotient bit.
  - The top block holds the FSM, counter and registers and instantiates it once.

Test Plan:
- Reset → all outputs 0. Then start with a=100, b=7 → done in the 17th cycle after the start edge; q=14, r=2, div_by_zero=0; busy low the cycle after done.
- a=16'hFFFF, b=1 → q=16'hFFFF, r=0; then a=16'hFFFF, b=16'hFFFF → q=1, r=0; then a=3, b=10 → q=0, r=3.
- a=5, b=0 → done on the 1st cycle after the start edge; q=16'hFFFF, r=5, div_by_zero=1. A following a=9, b=3 → q=3, r=0, div_by_zero=0.
- Start a=200, b=9; pulse start with a=1, b=1 during CALC and again during DONE → a single done with q=22, r=2; q and r hold the previous values throughout CALC.
- Start a=1000, b=3; assert rst_n=0 at the 8th CALC cycle → outputs 0 immediately, no done. After release, a=1000, b=3 → q=333, r=1.
- Self-check: random a and b (b≠0, 500 pairs) against q*b+r==a with r<b; include b=2^k and a=0.
